// File: rtl/output_delay_chain_bank.sv
// Multi-channel registered output-delay bank: a shared input word is steered
// round-robin into NUM_CH pipelines of DEPTH flops, each with a mode transform.

module output_delay_chain_bank_ref_ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else begin
      q <= d;
    end
  end

endmodule

module output_delay_chain_bank #(
  parameter  int NUM_CH = 4,
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 2,
  localparam int CW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    src_clk,
  input  logic                    rst_n,
  input  logic [WIDTH-1:0]        data_in,
  input  logic                    load_en,
  input  logic [1:0]              mode,
  output logic                    ref_q,
  output logic [CW-1:0]           ch_ptr,
  output logic [NUM_CH*WIDTH-1:0] port_out,
  output logic [NUM_CH-1:0]       port_valid
);

  localparam logic [1:0] MODE_PASS   = 2'd0;
  localparam logic [1:0] MODE_INVERT = 2'd1;
  localparam logic [1:0] MODE_ROTATE = 2'd2;
  localparam logic [1:0] MODE_COUNT  = 2'd3;

  logic load_cycle;

  assign load_cycle = load_en && (mode != MODE_COUNT);

  // Named instance so timing constraints can reference ff_ref/clk.
  output_delay_chain_bank_ref_ff ff_ref (
    .clk   (src_clk),
    .rst_n (rst_n),
    .d     (data_in[0]),
    .q     (ref_q)
  );

  // Round-robin pointer; with a single channel the wrap compare keeps it at 0.
  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_ptr <= '0;
    end else if (load_cycle) begin
      if (ch_ptr == CW'(NUM_CH - 1)) begin
        ch_ptr <= '0;
      end else begin
        ch_ptr <= ch_ptr + CW'(1);
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam int ROT = c % WIDTH;

    logic [WIDTH-1:0]            cnt;
    logic [WIDTH-1:0]            rot;
    logic [WIDTH-1:0]            xform;
    logic [DEPTH-1:0][WIDTH-1:0] data_q;
    logic [DEPTH-1:0]            valid_q;

    if (ROT == 0) begin : g_no_rot
      assign rot = data_in;
    end else begin : g_rot
      assign rot = {data_in[WIDTH-1-ROT:0], data_in[WIDTH-1:WIDTH-ROT]};
    end

    always_comb begin
      xform = data_in;
      case (mode)
        MODE_PASS:   xform = data_in;
        MODE_INVERT: xform = ~data_in;
        MODE_ROTATE: xform = rot;
        default:     xform = data_in;
      endcase
    end

    // Free-running counter, seeded with the channel index so channels differ.
    always_ff @(posedge src_clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= WIDTH'(c);
      end else begin
        cnt <= cnt + WIDTH'(1);
      end
    end

    // Stage 0 captures; later stages shift unconditionally so latency is fixed.
    always_ff @(posedge src_clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q  <= '0;
        valid_q <= '0;
      end else begin
        if (mode == MODE_COUNT) begin
          data_q[0]  <= cnt;
          valid_q[0] <= 1'b1;
        end else if (load_en && (ch_ptr == CW'(c))) begin
          data_q[0]  <= xform;
          valid_q[0] <= 1'b1;
        end else begin
          valid_q[0] <= 1'b0;
        end
        for (int s = 1; s < DEPTH; s++) begin
          data_q[s]  <= data_q[s-1];
          valid_q[s] <= valid_q[s-1];
        end
      end
    end

    assign port_out[c*WIDTH +: WIDTH] = data_q[DEPTH-1];
    assign port_valid[c]              = valid_q[DEPTH-1];
  end

endmodule

// File: doc/output_delay_chain_bank.md
Name: output_delay_chain_bank

Overview:
Parametrised multi-channel output-delay benchmark block for SDC set_output_delay characterisation. A shared input word is steered round-robin into NUM_CH independent registered output pipelines of DEPTH stages. Each channel applies a mode-selected transform before launch. A reference flop provides a -reference_pin target: instance ff_ref, pin ff_ref/clk. Top-level ports port_out/port_valid are the constrained output ports.

Parameters:
NUM_CH, 4, number of output channels (>=1)
WIDTH, 8, data width per channel (>=1)
DEPTH, 2, register stages per channel from capture to port (>=1)
CW, (NUM_CH>1 ? $clog2(NUM_CH) : 1), width of channel pointer (derived, not overridden)

Ports:
src_clk  in  1  single clock, all flops posedge
rst_n  in  1  asynchronous active-low reset
data_in  in  WIDTH  data word to launch
load_en  in  1  load data_in into channel at ch_ptr this edge
mode  in  2  transform: 0 pass, 1 invert, 2 rotate, 3 free-run counter
ref_q  out  1  reference flop output (ff_ref, D = data_in[0])
ch_ptr  out  CW  channel the next load targets
port_out  out  NUM_CH*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH], registered
port_valid  out  NUM_CH  one-cycle pulse per channel when new data reaches port_out

Behaviour:
- Reset (rst_n low, async, asserts regardless of clock): all pipeline data and valid stages 0; port_out = 0; port_valid = 0; ch_ptr = 0; ref_q = 0; channel counter cnt[c] = c mod 2^WIDTH. Release is synchronous to the next edge. Reset mid-operation discards all in-flight data, and no valid pulse emerges afterwards.
- ref_q: plain flop, ref_q <= data_in[0] every edge.
- Counters: cnt[c] <= cnt[c]+1 mod 2^WIDTH every edge in every mode.
- Transform T_c(x): mode 0 -> x. Mode 1 -> ~x. Mode 2 -> x rotated left by (c mod WIDTH). Mode 3 -> cnt[c] (the current value, before increment).
- Stage 1 per channel c, at each edge:
  - Modes 0-2 with load_en=1 and ch_ptr==c: data1 <= T_c(data_in), v1 <= 1.
  - Modes 0-2 otherwise: data1 holds, v1 <= 0.
  - Mode 3: data1 <= cnt[c], v1 <= 1 for all channels every edge; load_en is ignored.
- Stages 2..DEPTH shift unconditionally every edge (data and valid). port_out/port_valid are stage DEPTH.
- Latency: a value sampled at edge e is visible on port_out after edge e+DEPTH-1, with port_valid high for exactly that one cycle. port_out stays sticky at the last loaded value.
- ch_ptr:
  - Modes 0-2 with load_en=1: advances by 1, wrapping NUM_CH-1 -> 0.
  - Mode 3: holds.
  - NUM_CH=1: stays 0.
- Back-to-back loads go to successive channels, one per cycle, with no stall.
- Mode change takes effect at the edge where it is sampled. Data already in the pipeline is unaffected.
- No combinational path from any input to any output. Every output is driven directly by a flop.

Test Plan:
(NUM_CH=4, WIDTH=8, DEPTH=2 unless stated)
- Reset: rst_n low mid-run, no clock edge -> port_out=0, port_valid=0, ch_ptr=0, ref_q=0 immediately; after release, mode 3 first words are 0,1,2,3.
- Pass: mode 0, load 8'hA5 at edge 1 -> after edge 2, port_out[7:0]=A5, port_valid=4'b0001 for one cycle; ch_ptr=1; other channels stay 0.
- Round-robin wrap: mode 0, loads 11,22,33,44,55 on consecutive edges -> ch0..ch3 = 11,22,33,44, then ch0 becomes 55; ch_ptr sequence 1,2,3,0,1.
- Invert/rotate: mode 1, load 8'h0F to ch0 -> F0. Mode 2, load 8'h81 to ch1 -> 03; 8'h81 to ch2 -> 06; 8'h81 to ch3 -> 0C.
- Free-run: mode 3 for 5 edges with load_en=1 -> port_valid=4'b1111 every cycle; ch_ptr unchanged; ch2 shows consecutive values with +1 steps; wrap FF -> 00 checked.
- Parameter sweep: NUM_CH=1 and DEPTH=1 -> load visible after the same edge, ch_ptr stays 0. NUM_CH=3 -> ch_ptr wraps 2 -> 0.
